// File: rtl/air_hockey_pkg.sv
// Shared constants and types for the air-hockey frame pipeline.
//   NUM_TASKS          : number of per-frame update engines
//   TIMEOUT_CYCLES_DEF : default cycle budget per engine before it is abandoned
//   TASK_*             : engine index assignment on task_start / task_done
//   seq_state_t        : frame_sequencer FSM states
package air_hockey_pkg;

  localparam int NUM_TASKS          = 4;
  localparam int TIMEOUT_CYCLES_DEF = 65536;

  localparam int TASK_PUCK    = 0;
  localparam int TASK_MALLET  = 1;
  localparam int TASK_COLLIDE = 2;
  localparam int TASK_SCORE   = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_FIN   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/vs_edge_det.sv
// Falling-edge detector for the active-low VGA vertical sync.
//   clk        : pixel clock
//   rst        : asynchronous reset, active-low
//   vs         : vertical sync (same clock domain)
//   frame_tick : high for the cycle in which vs is low and was high last cycle
module vs_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic frame_tick
);

  logic vs_q;

  // Reset to 1 (sync idle level) so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vs_q <= 1'b1;
    else      vs_q <= vs;
  end

  assign frame_tick = vs_q & ~vs;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame sequencer: on each vs falling edge (when enabled) starts the
// update engines one at a time, waits for each to finish or time out, then
// counts the completed frame.
//   clk, rst      : clock, asynchronous active-low reset
//   vs            : VGA vertical sync, active-low
//   game_en       : permits new sequences to start
//   task_done     : per-engine completion pulses
//   clr_err       : clears the sticky overrun / timeout_err flags
//   task_start    : one-hot single-cycle start pulse
//   busy          : sequence in progress
//   frame_cnt     : completed sequences, wraps at 2^16
//   overrun       : sticky, frame tick arrived while busy
//   timeout_err   : sticky, an engine exceeded TIMEOUT_CYCLES
//   timeout_id    : index of the most recent timed-out engine
module frame_sequencer #(
  parameter  int NUM_TASKS      = air_hockey_pkg::NUM_TASKS,
  parameter  int TIMEOUT_CYCLES = air_hockey_pkg::TIMEOUT_CYCLES_DEF,
  localparam int IW             = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1,
  localparam int CW             = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vs,
  input  logic                 game_en,
  input  logic [NUM_TASKS-1:0] task_done,
  input  logic                 clr_err,
  output logic [NUM_TASKS-1:0] task_start,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic                 overrun,
  output logic                 timeout_err,
  output logic [IW-1:0]        timeout_id
);

  import air_hockey_pkg::seq_state_t, air_hockey_pkg::S_IDLE, air_hockey_pkg::S_START,
         air_hockey_pkg::S_WAIT, air_hockey_pkg::S_NEXT, air_hockey_pkg::S_FIN;

  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_TASKS - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic frame_tick;

  vs_edge_det u_vs_edge_det (
    .clk        (clk),
    .rst        (rst),
    .vs         (vs),
    .frame_tick (frame_tick)
  );

  seq_state_t           state_q;
  logic [IW-1:0]        idx_q;
  logic [CW-1:0]        tmo_cnt_q;
  logic [NUM_TASKS-1:0] task_start_q;
  logic                 busy_q;
  logic [15:0]          frame_cnt_q;
  logic                 overrun_q;
  logic                 timeout_err_q;
  logic [IW-1:0]        timeout_id_q;

  // Only the selected engine's done matters; done seen in START is ignored
  // because it is only examined in WAIT.
  logic done_sel, tmo_hit, ovr_set;
  assign done_sel = task_done[idx_q];
  // Done on the final budget cycle wins over the timeout.
  assign tmo_hit  = (state_q == S_WAIT) && !done_sel && (tmo_cnt_q == TMO_LAST);
  // Ticks while busy are dropped but flagged.
  assign ovr_set  = frame_tick && (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      tmo_cnt_q     <= '0;
      task_start_q  <= '0;
      busy_q        <= 1'b0;
      frame_cnt_q   <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      timeout_id_q  <= '0;
    end else begin
      task_start_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (frame_tick && game_en) begin
            idx_q        <= '0;
            task_start_q <= NUM_TASKS'(1);
            busy_q       <= 1'b1;
            state_q      <= S_START;
          end
        end
        S_START: begin
          tmo_cnt_q <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (done_sel) begin
            state_q <= S_NEXT;
          end else if (tmo_hit) begin
            timeout_id_q <= idx_q;
            state_q      <= S_NEXT;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
          end
        end
        S_NEXT: begin
          if (idx_q == IDX_LAST) begin
            state_q <= S_FIN;
          end else begin
            idx_q        <= idx_q + IW'(1);
            // Start pulse is registered so it lines up with the START state.
            task_start_q <= NUM_TASKS'(1) << (idx_q + IW'(1));
            state_q      <= S_START;
          end
        end
        S_FIN: begin
          frame_cnt_q <= frame_cnt_q + 16'd1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
      // Sticky flags: a set in the same cycle as clr_err takes priority.
      overrun_q     <= ovr_set | (overrun_q & ~clr_err);
      timeout_err_q <= tmo_hit | (timeout_err_q & ~clr_err);
    end
  end

  assign task_start  = task_start_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;
  assign timeout_id  = timeout_id_q;

endmodule
